// File: rtl/bus_owner_arbiter.sv
// Round-robin owner arbiter for a shared tristate bus: registered one-hot grant,
// one dead turnaround cycle between owners, and forced release after MAX_HOLD cycles.
module bus_owner_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic                    busy,
  output logic                    timeout
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned CW  = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] TURN  = 2'd2;

  localparam logic [IDW-1:0] LAST = IDW'(NREQ - 1);
  localparam logic [CW-1:0]  HOLD = CW'(MAX_HOLD);

  logic [1:0]      state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_d;
  logic [IDW-1:0]  gnt_id_d;
  logic            busy_d;
  logic            timeout_d;

  logic            found;
  logic [IDW-1:0]  win;
  logic [IDW:0]    cand;

  // Rotating scan: first set request at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!found && req[cand[IDW-1:0]]) begin
        found = 1'b1;
        win   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt;
    gnt_id_d  = gnt_id;
    busy_d    = busy;
    timeout_d = 1'b0;
    unique case (state_q)
      // TURN's closing edge arbitrates exactly like IDLE.
      IDLE, TURN: begin
        if (found) begin
          state_d     = GRANT;
          gnt_d       = '0;
          gnt_d[win]  = 1'b1;
          gnt_id_d    = win;
          busy_d      = 1'b1;
          ptr_d       = (win == LAST) ? '0 : win + IDW'(1);
          cnt_d       = CW'(1);
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end
      end
      GRANT: begin
        // A voluntary release outranks the hold limit, so no timeout on a tie.
        if (!req[gnt_id]) begin
          state_d = TURN;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end else if ((MAX_HOLD != 0) && (cnt_q == HOLD)) begin
          state_d   = TURN;
          gnt_d     = '0;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt     <= '0;
      gnt_id  <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt     <= gnt_d;
      gnt_id  <= gnt_id_d;
      busy    <= busy_d;
      timeout <= timeout_d;
    end
  end

endmodule

// File: tb/tb_bus_owner_arbiter.sv
// Bench for bus_owner_arbiter: two instances (hold limits 3 and 2) checked every cycle
// against an owner/tenure reference model, plus hand-computed directed sequences.
module tb_bus_owner_arbiter;

  localparam int N = 4;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req   = '0;

  logic [N-1:0] gnt_a, gnt_b;
  logic [1:0]   id_a, id_b;
  logic         busy_a, busy_b, to_a, to_b;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: owner index (-1 = none), cycles held so far, next priority index.
  int lim     [2] = '{3, 2};
  int m_owner [2];
  int m_ten   [2];
  int m_ptr   [2];
  bit m_to    [2];
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  bus_owner_arbiter #(.NREQ(N), .MAX_HOLD(3)) u_dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt_a),
    .gnt_id  (id_a),
    .busy    (busy_a),
    .timeout (to_a)
  );

  bus_owner_arbiter #(.NREQ(N), .MAX_HOLD(2)) u_dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt_b),
    .gnt_id  (id_b),
    .busy    (busy_b),
    .timeout (to_b)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int h = 0; h < 2; h++) begin
      m_owner[h] = -1;
      m_ten[h]   = 0;
      m_ptr[h]   = 0;
      m_to[h]    = 1'b0;
    end
  endtask

  function automatic bit req_bit(input int j);
    return ((req >> j) & 4'b0001) != 4'b0000;
  endfunction

  // With no owner (idle or just-released gap) the next edge arbitrates.
  task automatic model_step(input int h);
    bit to;
    bit got;
    int j;
    to  = 1'b0;
    got = 1'b0;
    if (m_owner[h] < 0) begin
      for (int i = 0; i < N; i++) begin
        j = (m_ptr[h] + i) % N;
        if (!got && req_bit(j)) begin
          got        = 1'b1;
          m_owner[h] = j;
          m_ten[h]   = 1;
          m_ptr[h]   = (j + 1) % N;
        end
      end
    end else if (!req_bit(m_owner[h])) begin
      m_owner[h] = -1;
    end else if (m_ten[h] == lim[h]) begin
      m_owner[h] = -1;
      to         = 1'b1;
    end else begin
      m_ten[h] = m_ten[h] + 1;
    end
    m_to[h] = to;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  task automatic check_inst(input string nm, input int h, input logic [N-1:0] g,
                            input logic [1:0] id, input logic b, input logic t);
    logic [N-1:0] eg;
    eg = (m_owner[h] >= 0) ? 4'(1 << m_owner[h]) : 4'b0000;
    check({nm, ".gnt"}, 32'(g), 32'(eg));
    check({nm, ".busy"}, 32'(b), 32'(m_owner[h] >= 0));
    check({nm, ".timeout"}, 32'(t), 32'(m_to[h]));
    if (m_owner[h] >= 0) begin
      check({nm, ".gnt_id"}, 32'(id), m_owner[h]);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check_inst("model_a", 0, gnt_a, id_a, busy_a, to_a);
      check_inst("model_b", 1, gnt_b, id_b, busy_b, to_b);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    cmp_en = 1'b1;

    // Reset state
    tick();
    check("rst_gnt_a", 32'(gnt_a), 32'h0);
    check("rst_busy_a", 32'(busy_a), 32'h0);
    check("rst_to_a", 32'(to_a), 32'h0);
    check("rst_gnt_b", 32'(gnt_b), 32'h0);
    do_reset();

    // Single requester: grant on first edge, release two edges later
    req = 4'b0100;
    tick();
    check("single_gnt", 32'(gnt_a), 32'h4);
    check("single_id", 32'(id_a), 32'd2);
    tick();
    req = 4'b0000;
    tick();
    check("single_release", 32'(gnt_a), 32'h0);
    check("single_no_to", 32'(to_a), 32'h0);
    tick();
    check("single_idle", 32'(busy_a), 32'h0);

    // Full contention, limit 3: owners 0,1,2,3,0, each 3 cycles then a timeout gap
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 17; c++) begin
      tick();
      if ((c % 4) == 3) begin
        check("contend_gap", 32'(gnt_a), 32'h0);
        check("contend_to", 32'(to_a), 32'h1);
      end else begin
        check("contend_gnt", 32'(gnt_a), 32'(1 << ((c / 4) % 4)));
        check("contend_to", 32'(to_a), 32'h0);
      end
    end

    // Sole requester, limit 2: 1000,1000,0000 repeating with timeout on the gap
    do_reset();
    req = 4'b1000;
    for (int c = 0; c < 9; c++) begin
      tick();
      check("sole_gnt_b", 32'(gnt_b), ((c % 3) == 2) ? 32'h0 : 32'h8);
      check("sole_to_b", 32'(to_b), ((c % 3) == 2) ? 32'h1 : 32'h0);
    end

    // Reset mid-grant drops the grant without a clock edge
    do_reset();
    req = 4'b0001;
    tick();
    check("mid_gnt", 32'(gnt_a), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_gnt", 32'(gnt_a), 32'h0);
    check("mid_rst_busy", 32'(busy_a), 32'h0);
    #2 rst_n = 1'b1;
    tick();
    check("mid_regrant", 32'(gnt_a), 32'h1);

    // Release handoff: one dead cycle, no timeout
    do_reset();
    req = 4'b0001;
    tick();
    check("hand_gnt0", 32'(gnt_a), 32'h1);
    req = 4'b0010;
    tick();
    check("hand_gap", 32'(gnt_a), 32'h0);
    check("hand_gap_to", 32'(to_a), 32'h0);
    tick();
    check("hand_gnt1", 32'(gnt_a), 32'h2);
    check("hand_to", 32'(to_a), 32'h0);

    // Drop on the limit edge (limit 2) gives no timeout; pointer wraps 3 -> 0
    do_reset();
    req = 4'b1000;
    tick();
    check("tie_gnt_1", 32'(gnt_b), 32'h8);
    tick();
    check("tie_gnt_2", 32'(gnt_b), 32'h8);
    req = 4'b0011;
    tick();
    check("tie_drop", 32'(gnt_b), 32'h0);
    check("tie_no_to", 32'(to_b), 32'h0);
    tick();
    check("wrap_gnt", 32'(gnt_b), 32'h1);
    check("wrap_id", 32'(id_b), 32'd0);

    // Randomized traffic with occasional asynchronous resets
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      req = req ^ 4'($urandom & $urandom);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #1;
        check("rand_rst_gnt_a", 32'(gnt_a), 32'h0);
        check("rand_rst_gnt_b", 32'(gnt_b), 32'h0);
        #3 rst_n = 1'b1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
